// File: rtl/onchip_memory_stream_reader.sv
// Reads a contiguous run of words from memory port 2 and emits them as a framed
// ready/valid stream, with a small credit-checked FIFO absorbing sink backpressure.
module onchip_memory_stream_reader #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned CNT_W      = 15,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_sop,
    output logic                st_eop
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W    = PTR_W + 1;
    localparam int unsigned SUM_W     = PTR_W + 2;
    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    reads_left_q, reads_left_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                tag_sop_q, tag_sop_d;
    logic                tag_eop_q, tag_eop_d;
    logic                rsp_q, rsp_d;
    logic                rsp_sop_q, rsp_sop_d;
    logic                rsp_eop_q, rsp_eop_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic                st_valid_q, st_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic                fifo_sop  [FIFO_DEPTH];
    logic                fifo_eop  [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic                credit_ok;
    logic [CNT_W-1:0]    count_clamped;

    // Next-state, read issue and FIFO bookkeeping
    always_comb begin
        state_d      = state_q;
        reads_left_d = reads_left_q;
        addr_d       = addr_q;
        cs_d         = 1'b0;
        tag_sop_d    = 1'b0;
        tag_eop_d    = 1'b0;
        done_d       = 1'b0;

        // Read data arrives one cycle after issue and is pushed that same cycle
        push      = rsp_q;
        pop       = st_valid_q & st_ready;
        rsp_d     = cs_q;
        rsp_sop_d = tag_sop_q;
        rsp_eop_d = tag_eop_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + FCNT_W'(push) - FCNT_W'(pop);

        // Next cycle holds count_d words plus the read issued now still in flight
        credit_ok = (SUM_W'(count_d) + SUM_W'(cs_q) + SUM_W'(1)) <= SUM_W'(FIFO_DEPTH);

        count_clamped = (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = S_FETCH;
                        cs_d         = 1'b1;
                        addr_d       = base_addr;
                        reads_left_d = count_clamped - CNT_W'(1);
                        tag_sop_d    = 1'b1;
                        tag_eop_d    = (count_clamped == CNT_W'(1));
                    end
                end
            end
            S_FETCH: begin
                if (reads_left_q == '0) begin
                    state_d = S_DRAIN;
                end else if (credit_ok) begin
                    cs_d         = 1'b1;
                    addr_d       = addr_q + ADDR_W'(1);
                    reads_left_d = reads_left_q - CNT_W'(1);
                    tag_eop_d    = (reads_left_q == CNT_W'(1));
                end
            end
            S_DRAIN: begin
                if (pop && fifo_eop[rd_ptr_q]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        st_valid_d = (count_d != '0);
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            reads_left_q <= '0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            tag_sop_q    <= 1'b0;
            tag_eop_q    <= 1'b0;
            rsp_q        <= 1'b0;
            rsp_sop_q    <= 1'b0;
            rsp_eop_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            st_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            reads_left_q <= reads_left_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            tag_sop_q    <= tag_sop_d;
            tag_eop_q    <= tag_eop_d;
            rsp_q        <= rsp_d;
            rsp_sop_q    <= rsp_sop_d;
            rsp_eop_q    <= rsp_eop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            st_valid_q   <= st_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // FIFO storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= mem_readdata;
            fifo_sop[wr_ptr_q]  <= rsp_sop_q;
            fifo_eop[wr_ptr_q]  <= rsp_eop_q;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;
    assign st_valid       = st_valid_q;
    assign st_data        = fifo_data[rd_ptr_q];
    assign st_sop         = st_valid_q & fifo_sop[rd_ptr_q];
    assign st_eop         = st_valid_q & fifo_eop[rd_ptr_q];

endmodule
